// File: rtl/grid_turn_sequencer.sv
// grid_turn_sequencer: game-step controller for the two-player 64x64 light-cycle grid.
// On each game tick it presents P1 and then P2 to the grid, one per cycle, and then
// samples the grid's win/crash flags. When no flag is set, it streams both head
// positions to the frame-buffer writer over a valid/ready handshake. Every output is
// registered. Each output register is loaded from the next-state decode, so an output
// becomes valid in the same cycle that its state becomes current.
module grid_turn_sequencer #(
  parameter int TICK_DIV = 500000,
  parameter int P1_X0    = 8,
  parameter int P1_Y0    = 32,
  parameter int P2_X0    = 55,
  parameter int P2_Y0    = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  dir_one,
  input  logic [1:0]  dir_two,
  input  logic        isWinOne,
  input  logic        isWinTwo,
  input  logic        isCrash,
  output logic [31:0] play_x,
  output logic [31:0] play_y,
  output logic        is_play_one,
  output logic        is_play_two,
  output logic        grid_reset,
  output logic [11:0] paint_addr,
  output logic [3:0]  paint_val,
  output logic        paint_valid,
  input  logic        paint_ready,
  output logic        game_over,
  output logic [1:0]  winner
);

  localparam int             CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0]  TC = CW'(TICK_DIV - 1);

  localparam logic [5:0] X1_0 = 6'(P1_X0);
  localparam logic [5:0] Y1_0 = 6'(P1_Y0);
  localparam logic [5:0] X2_0 = 6'(P2_X0);
  localparam logic [5:0] Y2_0 = 6'(P2_Y0);

  // Heading encoding matches the dir_* inputs. A 180-degree reverse flips bit 1.
  localparam logic [1:0] H_UP    = 2'b00;
  localparam logic [1:0] H_RIGHT = 2'b01;
  localparam logic [1:0] H_DOWN  = 2'b10;
  localparam logic [1:0] H_LEFT  = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE, S_CLEAR, S_WAIT_TICK, S_MOVE1, S_MOVE2,
    S_CHECK, S_PAINT1, S_PAINT2, S_OVER
  } state_t;

  state_t         r_state;
  state_t         w_state_nx;

  logic [CW-1:0]  r_cnt;
  logic [5:0]     r_p1x, r_p1y, r_p2x, r_p2y;
  logic [1:0]     r_h1, r_h2;

  logic [1:0]     w_h1, w_h2;
  logic [11:0]    w_p1, w_p2;
  logic           w_any_flag;
  logic [1:0]     w_win_nx;

  // A request for the exact reverse of the current heading is dropped.
  function automatic logic [1:0] turn(input logic [1:0] cur, input logic [1:0] req);
    return (req == (cur ^ 2'b10)) ? cur : req;
  endfunction

  // One step in heading h. The 6-bit arithmetic wraps at the grid edges.
  function automatic logic [11:0] step(input logic [5:0] x, input logic [5:0] y,
                                       input logic [1:0] h);
    logic [5:0] nx;
    logic [5:0] ny;
    nx = x;
    ny = y;
    case (h)
      H_UP:    ny = y - 6'd1;
      H_RIGHT: nx = x + 6'd1;
      H_DOWN:  ny = y + 6'd1;
      H_LEFT:  nx = x - 6'd1;
      default: ;
    endcase
    return {ny, nx};
  endfunction

  // Next-state decode, candidate head moves, and the winner encoding from the grid flags.
  always_comb begin
    w_state_nx = r_state;
    w_h1       = turn(r_h1, dir_one);
    w_h2       = turn(r_h2, dir_two);
    w_p1       = step(r_p1x, r_p1y, w_h1);
    w_p2       = step(r_p2x, r_p2y, w_h2);
    w_any_flag = isCrash | isWinOne | isWinTwo;
    w_win_nx   = 2'b00;
    if (isCrash || (isWinOne && isWinTwo)) w_win_nx = 2'b11;
    else if (isWinOne)                     w_win_nx = 2'b01;
    else if (isWinTwo)                     w_win_nx = 2'b10;

    case (r_state)
      S_IDLE:      if (start) w_state_nx = S_CLEAR;
      S_CLEAR:     w_state_nx = S_WAIT_TICK;
      S_WAIT_TICK: if (r_cnt == TC) w_state_nx = S_MOVE1;
      S_MOVE1:     w_state_nx = S_MOVE2;
      S_MOVE2:     w_state_nx = S_CHECK;
      S_CHECK:     w_state_nx = w_any_flag ? S_OVER : S_PAINT1;
      S_PAINT1:    if (paint_ready) w_state_nx = S_PAINT2;
      S_PAINT2:    if (paint_ready) w_state_nx = S_WAIT_TICK;
      S_OVER:      if (start) w_state_nx = S_CLEAR;
      default:     w_state_nx = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  // Tick counter. It runs only in WAIT_TICK and is zero on every entry to that state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                        r_cnt <= '0;
    else if (r_state == S_WAIT_TICK)   r_cnt <= r_cnt + CW'(1);
    else                               r_cnt <= '0;
  end

  // Head positions and headings. Each head commits on the edge into its MOVE state,
  // and both reload on every restart.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_p1x <= X1_0;  r_p1y <= Y1_0;  r_h1 <= H_RIGHT;
      r_p2x <= X2_0;  r_p2y <= Y2_0;  r_h2 <= H_LEFT;
    end else if (w_state_nx == S_CLEAR) begin
      r_p1x <= X1_0;  r_p1y <= Y1_0;  r_h1 <= H_RIGHT;
      r_p2x <= X2_0;  r_p2y <= Y2_0;  r_h2 <= H_LEFT;
    end else if (w_state_nx == S_MOVE1) begin
      {r_p1y, r_p1x} <= w_p1;
      r_h1           <= w_h1;
    end else if (w_state_nx == S_MOVE2) begin
      {r_p2y, r_p2x} <= w_p2;
      r_h2           <= w_h2;
    end
  end

  // Grid-side outputs. Only one enable is high in any cycle, and play_x/play_y are
  // zero outside MOVE1/MOVE2.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      play_x      <= '0;
      play_y      <= '0;
      is_play_one <= 1'b0;
      is_play_two <= 1'b0;
      grid_reset  <= 1'b1;
    end else begin
      grid_reset  <= (w_state_nx != S_CLEAR);
      is_play_one <= (w_state_nx == S_MOVE1);
      is_play_two <= (w_state_nx == S_MOVE2);
      if (w_state_nx == S_MOVE1) begin
        play_x <= {26'd0, w_p1[5:0]};
        play_y <= {26'd0, w_p1[11:6]};
      end else if (w_state_nx == S_MOVE2) begin
        play_x <= {26'd0, w_p2[5:0]};
        play_y <= {26'd0, w_p2[11:6]};
      end else begin
        play_x <= '0;
        play_y <= '0;
      end
    end
  end

  // Paint handshake. The positions do not change while painting, so addr/val stay
  // stable until the state advances on valid&ready.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      paint_valid <= 1'b0;
      paint_addr  <= '0;
      paint_val   <= '0;
    end else if (w_state_nx == S_PAINT1) begin
      paint_valid <= 1'b1;
      paint_addr  <= {r_p1y, r_p1x};
      paint_val   <= 4'b0000;
    end else if (w_state_nx == S_PAINT2) begin
      paint_valid <= 1'b1;
      paint_addr  <= {r_p2y, r_p2x};
      paint_val   <= 4'b0001;
    end else begin
      paint_valid <= 1'b0;
      paint_addr  <= '0;
      paint_val   <= '0;
    end
  end

  // Game result. The winner is captured when CHECK sees a flag, held through OVER,
  // and cleared on restart.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      game_over <= 1'b0;
      winner    <= 2'b00;
    end else begin
      game_over <= (w_state_nx == S_OVER);
      if (w_state_nx == S_CLEAR)
        winner <= 2'b00;
      else if (r_state == S_CHECK && w_any_flag)
        winner <= w_win_nx;
    end
  end

endmodule
